// File: rtl/poly1305_sequencer.sv
// rtl/poly1305_sequencer.sv - Poly1305 message sequencer around an external block processor
//
// Purpose:
//   Loads a one-time key, accepts 16-byte message blocks, pads each block and
//   hands it to an external multiply/reduce processor, then fully reduces the
//   accumulator and adds s to form the 128-bit authenticator.
//
// Optional feature:
//   POLY1305_SEQ_TIMEOUT_EN - adds a WAIT watchdog and the sticky err_timeout port.
//
// Ports:
//   clk, rst_ni            clock, asynchronous active-low reset
//   key, key_valid         256-bit one-time key {s, r}, load strobe (IDLE only)
//   msg_data, msg_bytes    message block (byte i at [8i+7:8i]) and byte count 0..16
//   msg_last               final block of the message
//   msg_valid, msg_ready   block handshake
//   pb_start               one-cycle start pulse to the block processor
//   pb_r, pb_m, pb_a_in    clamped r, padded block, current accumulator
//   pb_a_out, pb_done      processor result and its done pulse
//   tag, tag_valid         authenticator and its one-cycle valid pulse
//   err_timeout            sticky watchdog flag (only with POLY1305_SEQ_TIMEOUT_EN)

module poly1305_sequencer (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic [255:0] key,
  input  logic         key_valid,
  input  logic [127:0] msg_data,
  input  logic [4:0]   msg_bytes,
  input  logic         msg_last,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic         pb_start,
  output logic [127:0] pb_r,
  output logic [128:0] pb_m,
  output logic [129:0] pb_a_in,
  input  logic [129:0] pb_a_out,
  input  logic         pb_done,
  output logic [127:0] tag,
  output logic         tag_valid
`ifdef POLY1305_SEQ_TIMEOUT_EN
  ,
  output logic         err_timeout
`endif
);

  // Poly1305 prime 2^130 - 5 and the r clamp mask.
  localparam logic [129:0] P_PRIME = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [127:0] R_CLAMP = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    FREDUCE = 3'd4,
    TAGADD  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  r_q, r_d;
  logic [127:0]  s_q, s_d;
  logic [129:0]  acc_q, acc_d;
  logic [128:0]  pb_m_q, pb_m_d;
  logic          last_q, last_d;
  logic [127:0]  tag_q, tag_d;

`ifdef POLY1305_SEQ_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Padding datapath: keep bytes below n, zero the rest, set the 1 bit at 8n.
  logic [4:0]    n_eff;
  logic [128:0]  pad_m;

  always_comb begin
    n_eff = (msg_bytes > 5'd16) ? 5'd16 : msg_bytes;
    pad_m = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < n_eff) begin
        pad_m[8*i +: 8] = msg_data[8*i +: 8];
      end
    end
    pad_m[{n_eff, 3'b000}] = 1'b1;
  end

  // Final reduction: the processor keeps acc below 2^130, so one conditional
  // subtraction of P is enough. Bit 130 of the difference is the borrow.
  logic [130:0]  acc_minus_p;
  logic [127:0]  tag_sum;

  always_comb begin
    acc_minus_p = {1'b0, acc_q} - {1'b0, P_PRIME};
    tag_sum     = acc_q[127:0] + s_q;
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    s_d       = s_q;
    acc_d     = acc_q;
    pb_m_d    = pb_m_q;
    last_d    = last_q;
    tag_d     = tag_q;
    msg_ready = 1'b0;
    pb_start  = 1'b0;
    tag_valid = 1'b0;
`ifdef POLY1305_SEQ_TIMEOUT_EN
    cnt_d     = 8'd0;
    err_d     = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          r_d     = key[127:0] & R_CLAMP;
          s_d     = key[255:128];
          acc_d   = '0;
          state_d = ACCEPT;
        end
      end

      ACCEPT: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          last_d = msg_last;
          if (n_eff != 5'd0) begin
            pb_m_d  = pad_m;
            state_d = ISSUE;
          end else if (msg_last) begin
            // Empty final block: nothing to absorb, go straight to reduction.
            state_d = FREDUCE;
          end
          // Empty non-final block is consumed and dropped.
        end
      end

      ISSUE: begin
        pb_start = 1'b1;
        state_d  = WAIT;
      end

      WAIT: begin
`ifdef POLY1305_SEQ_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (pb_done) begin
          acc_d   = pb_a_out;
          state_d = last_q ? FREDUCE : ACCEPT;
`ifdef POLY1305_SEQ_TIMEOUT_EN
        end else if (cnt_d == 8'hff) begin
          // Processor never answered: abandon the message and drop the key.
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          r_d     = '0;
          s_d     = '0;
          state_d = IDLE;
`endif
        end
      end

      FREDUCE: begin
        if (!acc_minus_p[130]) begin
          acc_d = acc_minus_p[129:0];
        end
        state_d = TAGADD;
      end

      TAGADD: begin
        tag_d   = tag_sum;
        state_d = DONE;
      end

      DONE: begin
        tag_valid = 1'b1;
        r_d       = '0;
        s_d       = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      r_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      pb_m_q  <= '0;
      last_q  <= 1'b0;
      tag_q   <= '0;
`ifdef POLY1305_SEQ_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      pb_m_q  <= pb_m_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
`ifdef POLY1305_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign pb_r    = r_q;
  assign pb_m    = pb_m_q;
  assign pb_a_in = acc_q;
  assign tag     = tag_q;
`ifdef POLY1305_SEQ_TIMEOUT_EN
  assign err_timeout = err_q;
`endif

endmodule

// File: tb/tb_poly1305_sequencer.sv
// tb/tb_poly1305_sequencer.sv - self-checking bench for poly1305_sequencer
module tb_poly1305_sequencer;

  localparam logic [259:0] P260    = 260'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [127:0] CLAMP   = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;
  localparam logic [255:0] RFC_KEY = 256'h1bf54941aff6bf4afdb20dfb8a800301_a806d542fe52447f336d555778bed685;
  localparam logic [383:0] RFC_MSG = 384'h7075_6f7247206863726165736552206d7572_6f4620636968706172676f7470797243;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
  localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [255:0] key;
  logic         key_valid;
  logic [127:0] msg_data;
  logic [4:0]   msg_bytes;
  logic         msg_last;
  logic         msg_valid;
  logic         msg_ready;
  logic         pb_start;
  logic [127:0] pb_r;
  logic [128:0] pb_m;
  logic [129:0] pb_a_in;
  logic [129:0] pb_a_out = '0;
  logic         pb_done  = 1'b0;
  logic [127:0] tag;
  logic         tag_valid;
`ifdef POLY1305_SEQ_TIMEOUT_EN
  logic         err_timeout;
`endif

  always #5 clk = ~clk;

  poly1305_sequencer dut (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .key       (key),
    .key_valid (key_valid),
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .msg_last  (msg_last),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .pb_start  (pb_start),
    .pb_r      (pb_r),
    .pb_m      (pb_m),
    .pb_a_in   (pb_a_in),
    .pb_a_out  (pb_a_out),
    .pb_done   (pb_done),
    .tag       (tag),
    .tag_valid (tag_valid)
`ifdef POLY1305_SEQ_TIMEOUT_EN
    ,
    .err_timeout (err_timeout)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ((a + m) * r) mod P, straight from the Poly1305 definition.
  function automatic logic [129:0] mulmod(input logic [129:0] a, input logic [128:0] m,
                                          input logic [127:0] r);
    logic [259:0] t;
    t = ((260'(a) + 260'(m)) * 260'(r)) % P260;
    return t[129:0];
  endfunction

  function automatic logic [127:0] ref_tag(input logic [255:0] k, input logic [383:0] msg,
                                           input int len);
    logic [129:0] acc;
    logic [128:0] m;
    logic [127:0] r;
    int n;
    r = k[127:0] & CLAMP;
    acc = '0;
    for (int b = 0; b * 16 < len; b++) begin
      n = (len - 16 * b > 16) ? 16 : len - 16 * b;
      m = '0;
      for (int i = 0; i < n; i++) m[8*i +: 8] = msg[128*b + 8*i +: 8];
      m[8*n] = 1'b1;
      acc = mulmod(acc, m, r);
    end
    return acc[127:0] + k[255:128];
  endfunction

  function automatic logic [383:0] rnd384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Scoreboard and tag monitor.
  logic [127:0] exp_q[$];
  logic [127:0] mon_e;
  int           tag_seen = 0;

  always @(negedge clk) begin
    if (rst_ni && tag_valid) begin
      tag_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tag actual=%h required=no_tag", tag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tag", {132'b0, tag}, {132'b0, mon_e});
      end
    end
  end

  // Block processor model with programmable latency and a forced-result mode.
  int           proc_lat   = 2;
  bit           proc_en    = 1'b1;
  bit           proc_force = 1'b0;
  logic [129:0] proc_force_val = '0;
  bit           pend = 1'b0;
  int           pcnt = 0;
  int           start_cnt = 0;
  int           done_cnt = 0;
  logic [129:0] pres;
  logic [128:0] pbm_log[$];

  always @(negedge clk) begin
    pb_done = 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        pb_done  = proc_en;
        pb_a_out = pres;
        pend     = 1'b0;
        if (proc_en) done_cnt++;
      end else begin
        pcnt--;
      end
    end
    if (rst_ni && pb_start) begin
      start_cnt++;
      pbm_log.push_back(pb_m);
      pres = proc_force ? proc_force_val : mulmod(pb_a_in, pb_m, pb_r);
      pend = 1'b1;
      pcnt = proc_lat - 1;
    end
  end

  task automatic load_key(input logic [255:0] k);
    key = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic [4:0] nb, input logic last);
    int w;
    w = 0;
    while (!msg_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("msg_ready_wait", {259'b0, msg_ready}, 260'd1);
    msg_data  = d;
    msg_bytes = nb;
    msg_last  = last;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    msg_data  = rnd384()[127:0];
  endtask

  task automatic wait_tag(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tag_valid && n < budget);
    chk("tag_valid_seen", {259'b0, tag_valid}, 260'd1);
  endtask

  typedef struct {
    logic [255:0] k;
    logic [383:0] msg;
    int           len;
    bit           zero_first;
    bit           over;
    logic [127:0] exp;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t t, output int lat);
    int n;
    logic [4:0] nb;
    load_key(t.k);
    chk("pb_r_clamped", {132'b0, pb_r}, {132'b0, t.k[127:0] & CLAMP});
    exp_q.push_back(t.exp);
    if (t.zero_first) send_block(t.msg[127:0], 5'd0, 1'b0);
    if (t.len == 0) begin
      send_block(t.msg[127:0], 5'd0, 1'b1);
    end else begin
      for (int b = 0; b * 16 < t.len; b++) begin
        n  = (t.len - 16 * b > 16) ? 16 : t.len - 16 * b;
        nb = (n == 16 && t.over) ? 5'd31 : 5'(n);
        send_block(t.msg[128*b +: 128], nb, ((b + 1) * 16 >= t.len));
      end
    end
    wait_tag(400, lat);
  endtask

  initial begin
    int lat, s0, t0, d0, nblk;
    int lens[6];
    logic [255:0] k1, k2;
    logic [127:0] d;
    logic [129:0] fvals[3];
    logic [127:0] ftags[3];

    rst_ni = 1'b0; key = '0; key_valid = 1'b0;
    msg_data = '0; msg_bytes = '0; msg_last = 1'b0; msg_valid = 1'b0;

    lens = '{1, 15, 16, 17, 47, 48};
    vecs[0] = '{RFC_KEY, RFC_MSG, 34, 1'b0, 1'b0, RFC_TAG};
    vecs[1] = '{RFC_KEY, RFC_MSG, 0, 1'b0, 1'b0, RFC_S};
    for (int i = 0; i < 6; i++) begin
      vecs[i+2].k          = rnd384()[255:0];
      vecs[i+2].msg        = rnd384();
      vecs[i+2].len        = lens[i];
      vecs[i+2].zero_first = (lens[i] == 17 || lens[i] == 48);
      vecs[i+2].over       = (lens[i] == 16 || lens[i] == 48);
      vecs[i+2].exp        = ref_tag(vecs[i+2].k, vecs[i+2].msg, lens[i]);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", {259'b0, msg_ready}, 260'd0);
    chk("rst_tag_valid", {259'b0, tag_valid}, 260'd0);
    chk("rst_pb_start",  {259'b0, pb_start}, 260'd0);
    chk("rst_tag",       {132'b0, tag}, 260'd0);
    chk("rst_pb_a_in",   {130'b0, pb_a_in}, 260'd0);
    chk("rst_pb_r",      {132'b0, pb_r}, 260'd0);
    chk("rst_pb_m",      {131'b0, pb_m}, 260'd0);
`ifdef POLY1305_SEQ_TIMEOUT_EN
    chk("rst_err_timeout", {259'b0, err_timeout}, 260'd0);
`endif
    rst_ni = 1'b1;
    @(negedge clk);

    // A message offered in IDLE must not be taken (an empty last block would yield a tag).
    msg_valid = 1'b1; msg_bytes = 5'd0; msg_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_msg_ready", {259'b0, msg_ready}, 260'd0);
    msg_valid = 1'b0;
    @(negedge clk);

    // Table of vectors.
    for (int v = 0; v < NV; v++) begin
      proc_lat = 1 + v % 3;
      pbm_log.delete();
      s0 = start_cnt;
      run_vec(vecs[v], lat);
      nblk = (vecs[v].len + 15) / 16;
      chk("pb_start_count", 260'(start_cnt - s0), 260'(nblk));
      chk("latency", 260'(lat), (vecs[v].len == 0) ? 260'd2 : 260'(proc_lat + 3));
      if (v == 0 && pbm_log.size() == 3) chk("rfc_block3_pb_m", {131'b0, pbm_log[2]}, 260'h1_7075);
      @(negedge clk);
      chk("pb_r_cleared", {132'b0, pb_r}, 260'd0);
      chk("idle_after_tag", {259'b0, msg_ready}, 260'd0);
    end

    // Final reduction with a forced processor result and s = 0.
    fvals = '{P260[129:0] + 130'd3, P260[129:0], P260[129:0] - 130'd1};
    ftags = '{128'd3, 128'd0, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffa};
    proc_lat = 2;
    for (int i = 0; i < 3; i++) begin
      proc_force = 1'b1;
      proc_force_val = fvals[i];
      load_key({128'b0, rnd384()[127:0]});
      exp_q.push_back(ftags[i]);
      send_block(rnd384()[127:0], 5'd16, 1'b1);
      wait_tag(100, lat);
      proc_force = 1'b0;
      @(negedge clk);
    end

    // key_valid in WAIT is ignored; a new key right after tag_valid works.
    proc_lat = 5;
    k1 = rnd384()[255:0];
    k2 = rnd384()[255:0];
    d  = rnd384()[127:0];
    load_key(k1);
    exp_q.push_back(ref_tag(k1, {256'b0, d}, 16));
    send_block(d, 5'd16, 1'b1);
    @(negedge clk);
    key = k2;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("pb_r_kept_in_wait", {132'b0, pb_r}, {132'b0, k1[127:0] & CLAMP});
    wait_tag(100, lat);
    @(negedge clk);
    load_key(k2);
    chk("b2b_msg_ready", {259'b0, msg_ready}, 260'd1);
    chk("b2b_pb_r", {132'b0, pb_r}, {132'b0, k2[127:0] & CLAMP});
    exp_q.push_back(ref_tag(k2, {256'b0, d}, 7));
    send_block(d, 5'd7, 1'b1);
    wait_tag(100, lat);
    @(negedge clk);

    // Reset while WAITing; the late pb_done must be ignored.
    proc_lat = 3;
    load_key(rnd384()[255:0]);
    send_block(rnd384()[127:0], 5'd16, 1'b0);
    send_block(rnd384()[127:0], 5'd16, 1'b0);
    @(negedge clk);
    chk("acc_nonzero_in_wait", {259'b0, (pb_a_in != '0)}, 260'd1);
    t0 = tag_seen;
    d0 = done_cnt;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk);
    chk("late_pb_done_pulsed", 260'(done_cnt - d0), 260'd1);
    chk("rst_wait_no_tag", 260'(tag_seen - t0), 260'd0);
    chk("rst_wait_msg_ready", {259'b0, msg_ready}, 260'd0);
    chk("rst_wait_acc", {130'b0, pb_a_in}, 260'd0);
    chk("rst_wait_tag", {132'b0, tag}, 260'd0);
    chk("rst_wait_pb_r", {132'b0, pb_r}, 260'd0);

    // The RFC vector again after the abandoned message.
    proc_lat = 2;
    run_vec(vecs[0], lat);
    chk("rfc_again_latency", 260'(lat), 260'd5);
    @(negedge clk);

`ifdef POLY1305_SEQ_TIMEOUT_EN
    proc_en = 1'b0;
    t0 = tag_seen;
    load_key(rnd384()[255:0]);
    send_block(rnd384()[127:0], 5'd16, 1'b1);
    lat = 0;
    while (!err_timeout && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("timeout_cycles", 260'(lat), 260'd256);
    chk("timeout_idle", {259'b0, msg_ready}, 260'd0);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", {259'b0, err_timeout}, 260'd1);
    chk("timeout_no_tag", 260'(tag_seen - t0), 260'd0);
    proc_en = 1'b1;
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("timeout_cleared_by_reset", {259'b0, err_timeout}, 260'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 260'(exp_q.size()), 260'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
